// File: rtl/sa_output_deskew_if.sv
// Bus between the systolic array bottom row, the output deskew block and writeback.
// Optional out_last member exists only when SA_DESKEW_TILE_LAST_EN is defined.
interface sa_output_deskew_if #(
  parameter int N          = 4,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_accumulate;
  logic            stall_in;
  logic            stall_sa;
  logic            out_valid;
  logic            out_ready;
  logic [N*DW-1:0] out_data;
  logic [CW-1:0]   fifo_count;
  logic            skew_err;
`ifdef SA_DESKEW_TILE_LAST_EN
  logic            out_last;

  modport master (
    output in_valid, in_accumulate, stall_in, out_ready,
    input  stall_sa, out_valid, out_data, fifo_count, skew_err, out_last
  );
  modport slave (
    input  in_valid, in_accumulate, stall_in, out_ready,
    output stall_sa, out_valid, out_data, fifo_count, skew_err, out_last
  );
`else
  modport master (
    output in_valid, in_accumulate, stall_in, out_ready,
    input  stall_sa, out_valid, out_data, fifo_count, skew_err
  );
  modport slave (
    input  in_valid, in_accumulate, stall_in, out_ready,
    output stall_sa, out_valid, out_data, fifo_count, skew_err
  );
`endif
endinterface

// File: rtl/sa_output_deskew.sv
// Realigns skewed bottom-row accumulates into full rows, buffers them in a small FIFO
// and back-pressures the array. Define SA_DESKEW_TILE_LAST_EN to add per-tile out_last.

module sa_output_deskew_lane #(
  parameter int DEPTH = 1,
  parameter int DW    = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          hold_i,
  input  logic          vld_i,
  input  logic [DW-1:0] data_i,
  output logic          vld_o,
  output logic [DW-1:0] data_o
);
  logic [DEPTH-1:0]         vld_q;
  logic [DEPTH-1:0][DW-1:0] data_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q  <= '0;
      data_q <= '0;
    end else if (!hold_i) begin
      vld_q[0]  <= vld_i;
      data_q[0] <= data_i;
      for (int s = 1; s < DEPTH; s++) begin
        vld_q[s]  <= vld_q[s-1];
        data_q[s] <= data_q[s-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];
endmodule

module sa_output_deskew #(
  parameter int N          = 4,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TILE_ROWS  = 4
) (
  input logic                   CLK,
  input logic                   RST,
  sa_output_deskew_if.slave     bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [N-1:0]          lane_vld;
  logic [N-1:0][DW-1:0]  lane_data;
  logic [N*DW-1:0]       row;
  logic                  stall, full, aligned, partial, push, pop;

  logic [FIFO_DEPTH-1:0][N*DW-1:0] mem_q;
  logic [AW-1:0]   wptr_q, rptr_q, rptr_nxt;
  logic [CW-1:0]   count_q, count_d;
  logic [N*DW-1:0] out_data_q, out_data_d;
  logic            skew_err_q;

  // Column j is delayed N-1-j cycles so every column lines up with the last one.
  for (genvar j = 0; j < N; j++) begin : g_lane
    if (j == N-1) begin : g_direct
      assign lane_vld[j]  = bus.in_valid[j];
      assign lane_data[j] = bus.in_accumulate[j*DW +: DW];
    end else begin : g_chain
      sa_output_deskew_lane #(.DEPTH(N-1-j), .DW(DW)) u_lane (
        .CLK    (CLK),
        .RST    (RST),
        .hold_i (stall),
        .vld_i  (bus.in_valid[j]),
        .data_i (bus.in_accumulate[j*DW +: DW]),
        .vld_o  (lane_vld[j]),
        .data_o (lane_data[j])
      );
    end
  end

  assign row     = lane_data;
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign stall   = bus.stall_in | (full & ~bus.out_ready);
  assign aligned = &lane_vld;
  assign partial = (|lane_vld) & ~aligned;
  assign push    = aligned & ~stall;
  assign pop     = bus.out_valid & bus.out_ready;

  // out_data is the registered head, so recompute what the head will be after this edge.
  always_comb begin
    rptr_nxt   = pop ? rptr_q + AW'(1) : rptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    out_data_d = mem_q[rptr_nxt];
    if (count_q == CW'(pop)) out_data_d = push ? row : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      out_data_q <= '0;
      skew_err_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      rptr_q     <= rptr_nxt;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      if (partial && !stall) skew_err_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= row;
  end

  assign bus.stall_sa   = stall;
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_data   = out_data_q;
  assign bus.fifo_count = count_q;
  assign bus.skew_err   = skew_err_q;

`ifdef SA_DESKEW_TILE_LAST_EN
  localparam int TW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
  logic [TW-1:0]         tile_cnt_q;
  logic [FIFO_DEPTH-1:0] mem_last_q;
  logic                  push_last, out_last_q, out_last_d;

  assign push_last = (tile_cnt_q == TW'(TILE_ROWS-1));

  always_comb begin
    out_last_d = mem_last_q[rptr_nxt];
    if (count_q == CW'(pop)) out_last_d = push & push_last;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tile_cnt_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      if (push) tile_cnt_q <= push_last ? '0 : tile_cnt_q + TW'(1);
      out_last_q <= out_last_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_last_q[wptr_q] <= push_last;
  end

  assign bus.out_last = out_last_q;
`endif

  a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(push && !pop && full));
endmodule

// File: tb/tb_sa_output_deskew.sv
// Directed bench for sa_output_deskew: alignment latency, backpressure, full push/pop,
// skew fault, mid-operation reset and (with SA_DESKEW_TILE_LAST_EN) tile last marking.
module tb_sa_output_deskew;
  localparam int N = 4, DW = 16, FD = 4, TR = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  sa_output_deskew_if #(.N(N), .DW(DW), .FIFO_DEPTH(FD)) bus ();

  sa_output_deskew #(.N(N), .DW(DW), .FIFO_DEPTH(FD), .TILE_ROWS(TR)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] got_q[$];
  logic        got_last_q[$];
  logic [63:0] exp_q[$];

  always @(negedge CLK) begin
    if (!RST && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
`ifdef SA_DESKEW_TILE_LAST_EN
      got_last_q.push_back(bus.out_last);
`endif
    end
  end

  function automatic logic [63:0] row_val(input int base, input int r);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = 16'(base + r*16 + j);
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives n skewed rows (column j lags column 0 by j cycles); holds while stall_sa.
  task automatic drive_rows(input int n, input int base, input int skip_row,
                            input int skip_col, input int max_c);
    int c, budget, r;
    logic adv;
    logic [N-1:0] v;
    logic [63:0] d;
    c = 0;
    budget = 0;
    while (c < n + N - 1 && c < max_c) begin
      v = '0;
      d = '0;
      for (int j = 0; j < N; j++) begin
        r = c - j;
        if (r >= 0 && r < n && !(r == skip_row && j == skip_col)) begin
          v[j] = 1'b1;
          d[j*DW +: DW] = 16'(base + r*16 + j);
        end
      end
      bus.in_valid      = v;
      bus.in_accumulate = d;
      @(negedge CLK);
      adv = !bus.stall_sa;
      tick();
      if (adv) c++;
      budget++;
      if (budget > 200) begin
        check("drive_timeout", 64'(budget), 64'(200));
        break;
      end
    end
    bus.in_valid      = '0;
    bus.in_accumulate = '0;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (bus.out_valid && k < 50) begin
      tick();
      k++;
    end
    check(tag, 64'(bus.fifo_count), 64'(0));
  endtask

  task automatic compare_rows(input string tag);
    check({tag, "_n"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_row%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    got_last_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int k;
    RST               = 1'b1;
    bus.in_valid      = '0;
    bus.in_accumulate = '0;
    bus.stall_in      = 1'b1;
    bus.out_ready     = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", bus.out_data, 64'(0));
    check("rst_count", 64'(bus.fifo_count), 64'(0));
    check("rst_skew_err", 64'(bus.skew_err), 64'(0));
    check("rst_stall_follows_in1", 64'(bus.stall_sa), 64'(1));
    bus.stall_in = 1'b0;
    #1;
    check("rst_stall_follows_in0", 64'(bus.stall_sa), 64'(0));
    RST = 1'b0;
    tick();

    // Single row: column j presented one cycle after column j-1.
    bus.out_ready = 1'b1;
    for (int j = 0; j < N; j++) begin
      logic [63:0] d;
      d = '0;
      d[j*DW +: DW] = 16'(16'h0010 + j);
      bus.in_valid      = 4'(1 << j);
      bus.in_accumulate = d;
      tick();
      if (j == N-2) check("single_not_early", 64'(bus.out_valid), 64'(0));
    end
    bus.in_valid      = '0;
    bus.in_accumulate = '0;
    check("single_valid", 64'(bus.out_valid), 64'(1));
    check("single_data", bus.out_data, 64'h0013_0012_0011_0010);
    check("single_count", 64'(bus.fifo_count), 64'(1));
    tick();
    check("single_one_cycle", 64'(bus.out_valid), 64'(0));
    check("single_empty_data", bus.out_data, 64'(0));
    check("single_skew_err", 64'(bus.skew_err), 64'(0));
    exp_q.push_back(64'h0013_0012_0011_0010);
    compare_rows("single");

    // Backpressure: six rows into a 4-deep FIFO with the consumer stalled.
    bus.out_ready = 1'b0;
    for (int r = 0; r < 6; r++) exp_q.push_back(row_val(16'h0100, r));
    fork
      drive_rows(6, 16'h0100, -1, -1, 99);
      begin
        k = 0;
        while (bus.fifo_count != 3'd4 && k < 50) begin
          tick();
          k++;
        end
        check("bp_full_count", 64'(bus.fifo_count), 64'(4));
        check("bp_full_stall", 64'(bus.stall_sa), 64'(1));
        check("bp_head", bus.out_data, row_val(16'h0100, 0));
        repeat (3) tick();
        check("bp_head_stable", bus.out_data, row_val(16'h0100, 0));
        check("bp_count_hold", 64'(bus.fifo_count), 64'(4));
        bus.out_ready = 1'b1;
        @(negedge CLK);
        check("full_ready_no_stall", 64'(bus.stall_sa), 64'(0));
        tick();
        check("full_push_pop_count", 64'(bus.fifo_count), 64'(4));
        check("full_push_pop_head", bus.out_data, row_val(16'h0100, 1));
      end
    join
    wait_drain("bp_drain");
    check("bp_skew_err", 64'(bus.skew_err), 64'(0));
    compare_rows("bp");

    bus.stall_in = 1'b1;
    #1;
    check("ext_stall", 64'(bus.stall_sa), 64'(1));
    bus.stall_in = 1'b0;
    #1;

    // Skew fault: row 1 is missing column 2.
    drive_rows(3, 16'h0200, 1, 2, 99);
    check("skew_set", 64'(bus.skew_err), 64'(1));
    wait_drain("skew_drain");
    repeat (3) tick();
    check("skew_sticky", 64'(bus.skew_err), 64'(1));
    exp_q.push_back(row_val(16'h0200, 0));
    exp_q.push_back(row_val(16'h0200, 2));
    compare_rows("skew");

    // Reset with two rows buffered and one still in the deskew chains.
    bus.out_ready = 1'b0;
    drive_rows(3, 16'h0300, -1, -1, 5);
    check("pre_rst_count", 64'(bus.fifo_count), 64'(2));
    RST = 1'b1;
    tick();
    check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_count", 64'(bus.fifo_count), 64'(0));
    check("mid_rst_skew", 64'(bus.skew_err), 64'(0));
    check("mid_rst_data", bus.out_data, 64'(0));
    RST = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) tick();
    check("no_stale_valid", 64'(bus.out_valid), 64'(0));
    compare_rows("mid_rst");

`ifdef SA_DESKEW_TILE_LAST_EN
    for (int r = 0; r < 8; r++) exp_q.push_back(row_val(16'h0400, r));
    drive_rows(8, 16'h0400, -1, -1, 99);
    wait_drain("tile_drain");
    check("tile_last_n", 64'(got_last_q.size()), 64'(8));
    for (int i = 0; i < got_last_q.size(); i++)
      check($sformatf("tile_last%0d", i), 64'(got_last_q[i]), 64'((i == 3 || i == 7) ? 1 : 0));
    compare_rows("tile");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sa_output_deskew.md
Name: sa_output_deskew

Overview:
- Sits directly downstream of the systolic array's bottom MAC row.
- Captures each column's out_accumulate as it leaves the array. Column j emerges j cycles after column 0, so the block realigns the columns into one full result row.
- Buffers aligned rows in a small FIFO and drains them to the writeback path over a valid/ready handshake.
- Generates the stall_sa backpressure that freezes the array when the FIFO cannot accept.

Parameters:
- N, 4, array dimension (number of columns / lanes)
- DW, 16, data width per lane; matches the MAC accumulate width
- FIFO_DEPTH, 4, aligned-row FIFO entries; power of two, >= 2
- TILE_ROWS, 4, rows per output tile; used only by the optional feature

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous, active-high reset
- in_valid  input  N  per-column valid; bit j qualifies column j's accumulate
- in_accumulate  input  N*DW  bottom-row out_accumulate; lane j occupies bits [j*DW +: DW]
- stall_in  input  1  external stall from the array controller
- stall_sa  output  1  stall to every MAC stall_sa input; this block also freezes on it
- out_valid  output  1  aligned row available
- out_ready  input  1  consumer accepts the row
- out_data  output  N*DW  aligned row; lane j = column j
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries
- skew_err  output  1  sticky error: a partially valid row was seen at alignment

Behaviour:
- Clocking and reset:
  - Single clock domain; all state changes on the rising edge of CLK.
  - RST high at an edge clears the deskew registers (data and valid), the FIFO pointers and count, and skew_err.
  - Outputs after reset: out_valid=0, out_data=0, fifo_count=0, skew_err=0. stall_sa equals stall_in.
  - Reset mid-operation discards in-flight and buffered rows; there is no partial drain.
- Deskew:
  - Column j passes through a register chain of depth N-1-j. Column N-1 has depth 0 and is combinational.
  - Each stage holds data and valid.
  - A row whose column 0 enters at cycle t is aligned at cycle t+N-1 and pushed into the FIFO at the end of that cycle.
  - out_valid rises at cycle t+N when the FIFO was empty. There is no FIFO bypass.
- Stall:
  - stall_sa = stall_in OR (fifo_count == FIFO_DEPTH AND NOT out_ready). It is combinational from registered count.
  - While stall_sa is high: deskew chains hold, in_valid is ignored (the array is re-presenting held data), and no push occurs.
  - A pop still proceeds during stall_sa if out_valid && out_ready.
- Alignment check:
  - Aligned valid = AND of the N chain-output valids; partial = OR AND NOT AND.
  - When partial is true and stall_sa is low, skew_err sets and stays set until RST. The partial row is dropped, not pushed.
- FIFO:
  - Push = aligned valid && !stall_sa. Pop = out_valid && out_ready.
  - A simultaneous push and pop leaves count unchanged; this includes count == FIFO_DEPTH, where the full-and-ready case is allowed.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - out_data is registered from the head entry. It is stable while out_valid && !out_ready and equals 0 when empty.
  - Push to a full FIFO without a pop is impossible by construction. Verification asserts it never occurs.

Optional Feature:
- SA_DESKEW_TILE_LAST_EN defined:
  - Adds output out_last (1 bit), stored per FIFO entry.
  - out_last is asserted on the row that completes each group of TILE_ROWS pushed rows.
  - A push counter wraps to 0 after TILE_ROWS-1 and is reset by RST. Dropped partial rows do not count.
- Macro undefined: out_last port and counter are absent; all other behaviour is identical.

Test Plan:
- Single row, N=4, DW=16: column j driven with 16'h0010+j valid at cycle 10+j, out_ready=1 -> out_valid high at cycle 14 only; out_data lanes = {0013,0012,0011,0010} (lane 3 to lane 0); skew_err=0.
- Backpressure: 6 back-to-back rows, out_ready=0, FIFO_DEPTH=4 -> fifo_count reaches 4 and stall_sa=1. Raise out_ready -> rows drain in order with no loss or duplication; all 6 rows are emitted exactly once.
- Simultaneous push/pop at full: count=4, out_ready=1, new aligned row -> stall_sa=0, count stays 4, the new row is appended at the tail.
- Skew fault: row with in_valid for column 2 withheld -> no push; skew_err=1 and stays 1 until RST. Subsequent good rows still emit.
- Reset mid-operation: RST asserted while 2 rows are buffered and 1 is in flight -> next cycle out_valid=0, fifo_count=0, skew_err=0; no stale row appears afterward.
- With SA_DESKEW_TILE_LAST_EN, TILE_ROWS=4: 8 rows -> out_last=1 on rows 4 and 8 only.
